// File: rtl/ascii_recv_pkg.sv
// Shared definitions for the UART byte receiver: FSM state encoding and
// oversampling constants.
package ascii_recv_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } rx_state_e;

    localparam int unsigned Oversample = 16;
    localparam int unsigned StartMid   = 8;

endpackage

// File: rtl/rx_tick_gen.sv
// Oversample tick generator: one-cycle pulse every DIV clocks; clr restarts the
// count so ticks line up with the detected start edge.
module rx_tick_gen #(
    parameter int unsigned DIV = 651
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DIV - 1);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clr || cnt_q == CntLast) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick = (cnt_q == CntLast);

endmodule

// File: rtl/ascii_recv.sv
// UART 8N1 receiver with 16x oversampling and a small register FIFO for
// received bytes; reports framing errors and dropped bytes as pulses.
module ascii_recv
    import ascii_recv_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       empty,
    output logic       full,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned DIV  = CLK_HZ / (BAUD * Oversample);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam logic [PtrW:0] CountFull = (PtrW + 1)'(FIFO_DEPTH);

    logic rx_meta_q, rx_s_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    logic tick, tick_clr;

    rx_tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clr   (tick_clr),
        .tick  (tick)
    );

    rx_state_e  state_q, state_d;
    logic [3:0] tick_cnt_q, tick_cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       stop_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tick_clr   = 1'b0;
        stop_done  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!rx_s_q) begin
                    state_d    = StStart;
                    tick_clr   = 1'b1;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                end
            end
            StStart: begin
                if (tick) begin
                    if (tick_cnt_q == 4'(StartMid - 1)) begin
                        tick_cnt_d = '0;
                        state_d    = rx_s_q ? StIdle : StData;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end
            StData: begin
                // 4-bit tick count wraps naturally every 16 ticks
                if (tick) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == 4'(Oversample - 1)) begin
                        shift_d   = {rx_s_q, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = StStop;
                        end
                    end
                end
            end
            StStop: begin
                if (tick) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == 4'(Oversample - 1)) begin
                        stop_done = 1'b1;
                        state_d   = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   count_q;
    logic            frame_err_q, overrun_q;
    logic            stop_ok, pop, push;

    assign stop_ok = stop_done & rx_s_q;
    assign pop     = rd_en & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte
    assign push    = stop_ok & (~full | pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= shift_q;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
            frame_err_q <= stop_done & ~rx_s_q;
            overrun_q   <= stop_ok & full & ~pop;
        end
    end

    assign rd_data   = mem_q[rd_ptr_q];
    assign empty     = (count_q == '0);
    assign full      = (count_q == CountFull);
    assign rx_busy   = (state_q != StIdle);
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_ascii_recv.sv
// Self-checking bench for ascii_recv at default parameters; received bytes are
// tracked in a scoreboard queue and compared as they are read out.
module tb_ascii_recv;

    localparam int DIV   = 100_000_000 / (9600 * 16);
    localparam int BIT   = DIV * 16;
    // 2 synchronizer clocks + 1 start-detect clock, then stop sampled on tick
    // 8 + 9*16 = 152 after the start edge; the push lands on the next edge.
    localparam int LAT   = 3 + 152 * DIV;
    localparam int FRAME = 10 * BIT;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1;
    logic       rd_en = 1'b0;
    logic [7:0] rd_data;
    logic       empty, full, rx_busy, frame_err, overrun;

    int         checks = 0;
    int         failures = 0;
    int         ferr_cnt = 0;
    int         ovr_cnt = 0;
    logic [7:0] exp_q[$];

    ascii_recv dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .empty     (empty),
        .full      (full),
        .rx_busy   (rx_busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_err) ferr_cnt <= ferr_cnt + 1;
        if (overrun) ovr_cnt <= ovr_cnt + 1;
    end

    initial begin
        #40_000_000;
        $display("FAIL watchdog: run did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives ncyc clocks of a frame; optionally raises rd_en exactly across the push edge.
    task automatic send_frame(input logic [7:0] data, input logic stop, input bit pop_at_push,
                              input int ncyc, output int fall_at);
        logic was_empty;
        int   b;
        fall_at   = -1;
        was_empty = empty;
        for (int i = 0; i < ncyc; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            if (fall_at < 0 && was_empty && !empty) fall_at = i;
            was_empty = empty;
            b = i / BIT;
            if (b == 0) rx = 1'b0;
            else if (b <= 8) rx = data[b-1];
            else rx = stop;
            rd_en = pop_at_push && (i == LAT - 1);
        end
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        rx = 1'b1;
    endtask

    task automatic read_byte(input string name);
        logic [7:0] exp;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s: scoreboard has no expected byte, rd_data=%02h", name, rd_data);
            return;
        end
        exp = exp_q.pop_front();
        checks++;
        if (empty !== 1'b0) begin
            failures++;
            $display("FAIL %s_empty: got %b expected 0", name, empty);
        end
        checks++;
        if (rd_data !== exp) begin
            failures++;
            $display("FAIL %s_data: got %02h expected %02h", name, rd_data, exp);
        end
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if ({rd_data, empty, full, rx_busy, frame_err, overrun} !== {8'h00, 5'b10000}) begin
            failures++;
            $display("FAIL %s: got rd_data=%02h e=%b f=%b busy=%b ferr=%b ovr=%b expected 00 1 0 0 0 0",
                     name, rd_data, empty, full, rx_busy, frame_err, overrun);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_reset_outputs("reset_values");
        reset = 1'b1;
        idle(20);
        checks++;
        if (empty !== 1'b1 || rx_busy !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_idle: got empty=%b busy=%b expected 1 0", empty, rx_busy);
        end
    endtask

    task automatic test_single();
        int fall;
        exp_q.push_back(8'h41);
        send_frame(8'h41, 1'b1, 1'b0, FRAME, fall);
        checks++;
        if (fall != LAT) begin
            failures++;
            $display("FAIL push_latency: got %0d expected %0d", fall, LAT);
        end
        checks++;
        if (full !== 1'b0) begin
            failures++;
            $display("FAIL single_full: got %b expected 0", full);
        end
        read_byte("single_41");
        checks++;
        if (empty !== 1'b1) begin
            failures++;
            $display("FAIL single_empty_after_read: got %b expected 1", empty);
        end
        idle(BIT);
    endtask

    task automatic test_glitch();
        int f0;
        f0 = ferr_cnt;
        rx = 1'b0;
        repeat (3 * DIV) @(posedge clk);
        #1;
        checks++;
        if (rx_busy !== 1'b1) begin
            failures++;
            $display("FAIL glitch_busy: got %b expected 1", rx_busy);
        end
        idle(2 * BIT);
        checks++;
        if (rx_busy !== 1'b0 || empty !== 1'b1 || ferr_cnt != f0) begin
            failures++;
            $display("FAIL glitch_reject: got busy=%b empty=%b ferr=%0d expected 0 1 0",
                     rx_busy, empty, ferr_cnt - f0);
        end
    endtask

    task automatic test_frame_err();
        int f0, fall;
        f0 = ferr_cnt;
        send_frame(8'h55, 1'b0, 1'b0, FRAME, fall);
        idle(2 * BIT);
        checks++;
        if (ferr_cnt - f0 != 1) begin
            failures++;
            $display("FAIL frame_err_pulse: got %0d cycles expected 1", ferr_cnt - f0);
        end
        checks++;
        if (empty !== 1'b1 || rx_busy !== 1'b0) begin
            failures++;
            $display("FAIL frame_err_empty: got empty=%b busy=%b expected 1 0", empty, rx_busy);
        end
    endtask

    task automatic test_overrun();
        int o0, fall;
        logic [7:0] d;
        for (int k = 0; k < 5; k++) begin
            d = 8'h30 + 8'(k);
            o0 = ovr_cnt;
            if (exp_q.size() < 4) exp_q.push_back(d);
            send_frame(d, 1'b1, 1'b0, FRAME, fall);
            idle(BIT / 2);
            checks++;
            if (full !== (k >= 3)) begin
                failures++;
                $display("FAIL full_after_%02h: got %b expected %b", d, full, k >= 3);
            end
            checks++;
            if (ovr_cnt - o0 != ((k == 4) ? 1 : 0)) begin
                failures++;
                $display("FAIL overrun_on_%02h: got %0d expected %0d", d, ovr_cnt - o0,
                         (k == 4) ? 1 : 0);
            end
        end
    endtask

    task automatic test_back_to_back();
        int o0, fall;
        logic [7:0] exp;
        // Head is popped on the same edge 0x39 is pushed into the full FIFO
        exp = exp_q.pop_front();
        checks++;
        if (rd_data !== exp) begin
            failures++;
            $display("FAIL coincident_head: got %02h expected %02h", rd_data, exp);
        end
        exp_q.push_back(8'h39);
        o0 = ovr_cnt;
        send_frame(8'h39, 1'b1, 1'b1, FRAME, fall);
        idle(BIT / 2);
        checks++;
        if (ovr_cnt != o0 || full !== 1'b1) begin
            failures++;
            $display("FAIL coincident_push_pop: got ovr=%0d full=%b expected 0 1",
                     ovr_cnt - o0, full);
        end
        for (int k = 0; k < 4; k++) read_byte("drain");
        checks++;
        if (empty !== 1'b1 || full !== 1'b0) begin
            failures++;
            $display("FAIL drained: got empty=%b full=%b expected 1 0", empty, full);
        end
    endtask

    task automatic test_reset_mid_frame();
        int fall;
        exp_q.push_back(8'h77);
        send_frame(8'h77, 1'b1, 1'b0, FRAME, fall);
        idle(BIT / 2);
        send_frame(8'h12, 1'b1, 1'b0, 4 * BIT + BIT / 2, fall);
        rx = 1'b0;
        checks++;
        if (rx_busy !== 1'b1 || empty !== 1'b0) begin
            failures++;
            $display("FAIL mid_frame_state: got busy=%b empty=%b expected 1 0", rx_busy, empty);
        end
        reset = 1'b0;
        #1;
        check_reset_outputs("reset_async");
        exp_q.delete();
        repeat (10) @(posedge clk);
        #1;
        check_reset_outputs("reset_held");
        rx = 1'b1;
        reset = 1'b1;
        idle(BIT);
        checks++;
        if (empty !== 1'b1) begin
            failures++;
            $display("FAIL partial_not_pushed: got empty=%b expected 1", empty);
        end
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 1'b0, FRAME, fall);
        idle(BIT / 2);
        read_byte("after_reset_5a");
        checks++;
        if (empty !== 1'b1) begin
            failures++;
            $display("FAIL after_reset_empty: got %b expected 1", empty);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_back_to_back();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ascii_recv.md
ASCII_RECV -- requirements
Module: ascii_recv

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, serial bit rate.
REQ-003 Parameter FIFO_DEPTH, default 4, received-byte buffer depth; power of two, at least 2.
REQ-004 Port clk, input, 1, single system clock; all logic on its rising edge.
REQ-005 Port reset, input, 1, asynchronous active-low reset; low = reset.
REQ-006 Port rx, input, 1, UART serial input, 8N1, LSB first, idle high; asynchronous to clk.
REQ-007 Port rd_en, input, 1, pop request for the FIFO head.
REQ-008 Port rd_data, output, 8, FIFO head byte; valid while empty=0.
REQ-009 Port empty, output, 1, FIFO holds no bytes.
REQ-010 Port full, output, 1, FIFO holds FIFO_DEPTH bytes.
REQ-011 Port rx_busy, output, 1, receiver FSM not in IDLE.
REQ-012 Port frame_err, output, 1, one-cycle pulse on an invalid stop bit.
REQ-013 Port overrun, output, 1, one-cycle pulse when a good byte is dropped because the FIFO is full.

Function
REQ-014 rx SHALL pass through a 2-flop synchronizer; downstream logic SHALL use only the synchronized value (rx_s).
REQ-015 Oversample tick: one-cycle pulse every DIV = CLK_HZ/(BAUD*16) clocks, integer-truncated (651 at defaults).
REQ-016 Tick counter: runs 0..DIV-1 and wraps; it SHALL clear to 0 on the IDLE->START transition so sampling is phase-aligned to the start edge.
REQ-017 FSM states: IDLE, START, DATA, STOP.
REQ-018 IDLE: on rx_s=0, go to START.
REQ-019 START: on tick 8, if rx_s=0 go to DATA, otherwise return to IDLE (glitch rejection, no output).
REQ-020 DATA: sample rx_s every 16 ticks, shifting into bit 7 down to 0 (LSB first); after the 8th sample go to STOP.
REQ-021 STOP: sample rx_s after 16 ticks, then return to IDLE. Outcome by condition:
- stop=1 and FIFO not full: push the byte.
- stop=1 and FIFO full: drop the byte and pulse overrun.
- stop=0: pulse frame_err and discard the byte.
REQ-022 Push latency: empty SHALL deassert and rd_data SHALL show the byte on the clock after the stop sample.
REQ-023 Pop: rd_en with empty=0 advances the head on that edge; rd_en with empty=1 is ignored with no state change.
REQ-024 Push and pop in the same cycle: both SHALL occur, including when full, in which case no overrun is signalled and the count is unchanged.
REQ-025 Pointer widths: read and write pointers SHALL be log2(FIFO_DEPTH) bits with natural wrap; the count SHALL be log2(FIFO_DEPTH)+1 bits.
REQ-026 Flags: full = (count == FIFO_DEPTH); empty = (count == 0).
REQ-027 rx_busy SHALL be 1 in START, DATA and STOP.

Reset
REQ-028 While reset=0, the block SHALL immediately force the following, regardless of clk:
- FSM to IDLE; tick, bit and pointer counters to 0;
- synchronizer flops to 1; rd_data to 0x00;
- empty=1, full=0, rx_busy=0, frame_err=0, overrun=0.
REQ-029 Reset asserted mid-frame SHALL abandon the partial byte, which is never pushed; the first frame after release SHALL receive correctly.

Structure
REQ-030 A shared package SHALL hold the FSM state enum (2 bits), the oversample factor 16, and the start mid-point tick 8.
REQ-031 The oversample tick generator SHALL be a sub-module, rx_tick_gen, with inputs clk, reset, clr and output tick.
REQ-032 The FIFO SHALL be inline, register-based, with no vendor memory primitives.

Verification
REQ-033 All scenarios SHALL use the default parameters: 1 bit = 10416 clocks.
REQ-034 Frame 0x41 ('A') -> empty falls one clock after the stop sample; rd_data=0x41; one rd_en pulse -> empty=1.
REQ-035 rx low for 3 ticks, then high -> returns to IDLE; no push, no frame_err; empty stays 1.
REQ-036 Frame 0x55 with stop bit 0 -> frame_err pulses for exactly 1 clock; FIFO stays empty.
REQ-037 Frames 0x30..0x34 with no reads -> full=1 after 0x33; overrun pulses once on 0x34; four reads return 0x30, 0x31, 0x32, 0x33.
REQ-038 FIFO full, and rd_en coincides with the push of 0x39 -> no overrun; full stays 1; the final read returns 0x39.
REQ-039 reset pulsed low during DATA bit 3 -> all outputs at reset values; the following frame 0x5A is read back as 0x5A.
